// File: rtl/sipo_pkg.sv
// sipo_pkg: shared types and constants for the serial-in/parallel-out
// deserializer slice.
//   sipo_state_t        framing FSM state (HUNT = waiting for alignment,
//                       SHIFT = collecting bits of a word)
//   SIPO_DEFAULT_WIDTH  default word width
//   cnt_width()         width of a counter able to hold 0..w
package sipo_pkg;

  typedef enum logic {
    HUNT  = 1'b0,
    SHIFT = 1'b1
  } sipo_state_t;

  localparam int unsigned SIPO_DEFAULT_WIDTH = 4;

  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/sipo_bit_counter.sv
// sipo_bit_counter: bit position counter for the deserializer.
//   clk    in   rising-edge clock
//   rst    in   asynchronous active-high reset (count -> 0)
//   load   in   start of a new word: this sample is bit 0, count becomes 1
//   inc    in   one more bit sampled, count increments
//   count  out  bits collected in the current partial word (0..WIDTH-1)
//   done   out  combinational pulse: the current sample completes the word;
//               count wraps to 0 on the same edge
module sipo_bit_counter
  import sipo_pkg::*;
#(
  parameter int unsigned WIDTH = SIPO_DEFAULT_WIDTH,
  parameter int unsigned CW    = cnt_width(WIDTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          inc,
  output logic [CW-1:0] count,
  output logic          done
);

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  // load takes priority over inc; a load completes immediately only for a
  // one-bit word (LAST == 0).
  always_comb begin
    done = 1'b0;
    if (load) begin
      done = (LAST == '0);
    end else if (inc) begin
      done = (count == LAST);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (done) begin
      count <= '0;
    end else if (load) begin
      count <= CW'(1);
    end else if (inc) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/sipo_deser.sv
// sipo_deser: serial-in/parallel-out deserializer with start-of-word
// alignment, a one-entry output holding register and sticky error flags.
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   sin        in   serial data bit
//   sin_en     in   sin is sampled only when 1
//   sin_sof    in   with sin_en: this bit is bit 0 of a new word
//   out_data   out  assembled word, stable while out_valid=1
//   out_valid  out  holding register full
//   out_ready  in   consumer accepts when out_valid & out_ready
//   overrun    out  sticky: completed word dropped, holding register full
//   frame_err  out  sticky: sin_sof arrived mid-word
//   err_clr    in   synchronous clear of overrun and frame_err
//   bit_cnt    out  bits collected in the current partial word
module sipo_deser
  import sipo_pkg::*;
#(
  parameter int unsigned WIDTH     = SIPO_DEFAULT_WIDTH,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sin,
  input  logic                       sin_en,
  input  logic                       sin_sof,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       overrun,
  output logic                       frame_err,
  input  logic                       err_clr,
  output logic [$clog2(WIDTH+1)-1:0] bit_cnt
);

  localparam int unsigned CW = cnt_width(WIDTH);

  sipo_state_t      state;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_start;
  logic [WIDTH-1:0] sr_shift;
  logic [WIDTH-1:0] word;
  logic             load;
  logic             inc;
  logic             done;
  logic             frame_set;
  logic             over_set;

  // sof always restarts a word; plain bits only count once aligned.
  assign load = sin_en & sin_sof;
  assign inc  = sin_en & ~sin_sof & (state == SHIFT);

  sipo_bit_counter #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .inc   (inc),
    .count (bit_cnt),
    .done  (done)
  );

  // MSB-first shifts left inserting at bit 0, so the first bit ends in the
  // MSB; LSB-first shifts right inserting at the top, so it ends in bit 0.
  if (MSB_FIRST) begin : g_msb
    assign sr_start = {{(WIDTH-1){1'b0}}, sin};
    assign sr_shift = {sr[WIDTH-2:0], sin};
  end else begin : g_lsb
    assign sr_start = {sin, {(WIDTH-1){1'b0}}};
    assign sr_shift = {sin, sr[WIDTH-1:1]};
  end

  // The completing bit is not yet in sr, so the word is taken from the
  // shifted value that sr would receive on this edge.
  assign word      = load ? sr_start : sr_shift;
  assign frame_set = load & (state == SHIFT) & (bit_cnt != '0);
  assign over_set  = done & out_valid & ~out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= HUNT;
    end else if (load) begin
      state <= SHIFT;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr <= '0;
    end else if (load) begin
      sr <= sr_start;
    end else if (inc) begin
      sr <= sr_shift;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (done) begin
      if (!out_valid || out_ready) begin
        out_data  <= word;
        out_valid <= 1'b1;
      end
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // A new error in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      overrun   <= over_set  | (overrun   & ~err_clr);
      frame_err <= frame_set | (frame_err & ~err_clr);
    end
  end

endmodule

// File: tb/tb_sipo_deser.sv
module tb_sipo_deser;

  logic       clk = 1'b0;
  logic       rst, sin, sin_en, sin_sof, out_ready, err_clr;
  logic [3:0] out_data, lsb_data;
  logic       out_valid, overrun, frame_err;
  logic       lsb_valid, lsb_over, lsb_ferr;
  logic [2:0] bit_cnt, lsb_cnt;
  int         tests  = 0;
  int         failed = 0;

  always #5 clk = ~clk;

  sipo_deser #(.WIDTH(4), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst), .sin(sin), .sin_en(sin_en), .sin_sof(sin_sof),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .overrun(overrun), .frame_err(frame_err), .err_clr(err_clr),
    .bit_cnt(bit_cnt)
  );

  sipo_deser #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .sin(sin), .sin_en(sin_en), .sin_sof(sin_sof),
    .out_data(lsb_data), .out_valid(lsb_valid), .out_ready(out_ready),
    .overrun(lsb_over), .frame_err(lsb_ferr), .err_clr(err_clr),
    .bit_cnt(lsb_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic b, input logic sof);
    sin = b; sin_sof = sof; sin_en = 1'b1;
    step();
    sin_en = 1'b0; sin_sof = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; sin = 0; sin_en = 0; sin_sof = 0; out_ready = 0; err_clr = 0;
    step(); step();
    tests++; if (out_data !== 4'h0) begin failed++; $display("FAIL reset_data got %h exp 0", out_data); end
    tests++; if (out_valid !== 1'b0) begin failed++; $display("FAIL reset_valid got %b exp 0", out_valid); end
    tests++; if (bit_cnt !== 3'd0) begin failed++; $display("FAIL reset_cnt got %0d exp 0", bit_cnt); end
    tests++; if ({overrun, frame_err} !== 2'b00) begin failed++; $display("FAIL reset_flags got %b exp 00", {overrun, frame_err}); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    send(1, 1);
    tests++; if (bit_cnt !== 3'd1) begin failed++; $display("FAIL t1_cnt1 got %0d exp 1", bit_cnt); end
    send(0, 0); send(1, 0);
    tests++; if (out_valid !== 1'b0) begin failed++; $display("FAIL t1_early_valid got %b exp 0", out_valid); end
    send(1, 0);
    tests++; if (out_valid !== 1'b1) begin failed++; $display("FAIL t1_valid got %b exp 1", out_valid); end
    tests++; if (out_data !== 4'b1011) begin failed++; $display("FAIL t1_data got %b exp 1011", out_data); end
    tests++; if (lsb_data !== 4'b1101) begin failed++; $display("FAIL t1_lsb_data got %b exp 1101", lsb_data); end
    tests++; if (bit_cnt !== 3'd0) begin failed++; $display("FAIL t1_cnt_wrap got %0d exp 0", bit_cnt); end
    step();
    tests++; if (out_valid !== 1'b0) begin failed++; $display("FAIL t1_accept got %b exp 0", out_valid); end
    tests++; if (out_data !== 4'b1011) begin failed++; $display("FAIL t1_data_hold got %b exp 1011", out_data); end
  endtask

  task automatic test_no_sof();
    do_reset();
    out_ready = 1'b1;
    send(1, 0); send(1, 0); send(0, 0); send(0, 0);
    tests++; if (out_valid !== 1'b0) begin failed++; $display("FAIL t2_valid got %b exp 0", out_valid); end
    tests++; if (bit_cnt !== 3'd0) begin failed++; $display("FAIL t2_cnt got %0d exp 0", bit_cnt); end
    send(0, 1); send(1, 0); send(1, 0); send(0, 0);
    tests++; if ({out_valid, out_data} !== 5'b1_0110) begin failed++; $display("FAIL t2_word got %b exp 10110", {out_valid, out_data}); end
    step();
  endtask

  task automatic test_overrun();
    out_ready = 1'b0;
    send(1, 0); send(0, 0); send(1, 0); send(0, 0);
    tests++; if ({out_valid, out_data} !== 5'b1_1010) begin failed++; $display("FAIL t3_first got %b exp 11010", {out_valid, out_data}); end
    tests++; if (lsb_data !== 4'b0101) begin failed++; $display("FAIL t3_lsb_data got %b exp 0101", lsb_data); end
    send(0, 0); send(1, 0); send(0, 0); send(1, 0);
    tests++; if (out_data !== 4'hA) begin failed++; $display("FAIL t3_keep got %h exp a", out_data); end
    tests++; if (overrun !== 1'b1) begin failed++; $display("FAIL t3_overrun got %b exp 1", overrun); end
    err_clr = 1'b1; step(); err_clr = 1'b0;
    tests++; if (overrun !== 1'b0) begin failed++; $display("FAIL t3_clr got %b exp 0", overrun); end
    tests++; if (out_valid !== 1'b1) begin failed++; $display("FAIL t3_still_held got %b exp 1", out_valid); end
  endtask

  task automatic test_back_to_back();
    send(0, 0); send(0, 0); send(1, 0);
    out_ready = 1'b1;
    send(1, 0);
    tests++; if ({out_valid, out_data} !== 5'b1_0011) begin failed++; $display("FAIL t4_word got %b exp 10011", {out_valid, out_data}); end
    tests++; if (overrun !== 1'b0) begin failed++; $display("FAIL t4_overrun got %b exp 0", overrun); end
    step();
    tests++; if (out_valid !== 1'b0) begin failed++; $display("FAIL t4_drain got %b exp 0", out_valid); end
  endtask

  task automatic test_clr_priority();
    out_ready = 1'b0;
    send(1, 0); send(1, 0); send(1, 0); send(1, 0);
    send(0, 0); send(0, 0); send(0, 0);
    err_clr = 1'b1; send(0, 0); err_clr = 1'b0;
    tests++; if (overrun !== 1'b1) begin failed++; $display("FAIL clr_prio got %b exp 1", overrun); end
    tests++; if (out_data !== 4'hF) begin failed++; $display("FAIL clr_prio_data got %h exp f", out_data); end
    err_clr = 1'b1; step(); err_clr = 1'b0;
    tests++; if (overrun !== 1'b0) begin failed++; $display("FAIL clr_after got %b exp 0", overrun); end
    out_ready = 1'b1; step();
  endtask

  task automatic test_frame_err();
    out_ready = 1'b1;
    send(1, 1); send(1, 0);
    tests++; if ({bit_cnt, frame_err} !== 4'b010_0) begin failed++; $display("FAIL t5_pre got %b exp 0100", {bit_cnt, frame_err}); end
    send(0, 1);
    tests++; if ({bit_cnt, frame_err} !== 4'b001_1) begin failed++; $display("FAIL t5_err got %b exp 0011", {bit_cnt, frame_err}); end
    send(1, 0); send(1, 0); send(0, 0);
    tests++; if ({out_valid, out_data} !== 5'b1_0110) begin failed++; $display("FAIL t5_word got %b exp 10110", {out_valid, out_data}); end
    tests++; if (frame_err !== 1'b1) begin failed++; $display("FAIL t5_sticky got %b exp 1", frame_err); end
    err_clr = 1'b1; step(); err_clr = 1'b0;
    tests++; if (frame_err !== 1'b0) begin failed++; $display("FAIL t5_clr got %b exp 0", frame_err); end
    send(1, 1); send(0, 0); send(0, 0); send(1, 0);
    tests++; if ({frame_err, out_data} !== 5'b0_1001) begin failed++; $display("FAIL t5_aligned_sof got %b exp 01001", {frame_err, out_data}); end
    step();
  endtask

  task automatic test_mid_reset();
    out_ready = 1'b0;
    send(1, 1); send(0, 0); send(0, 0); send(1, 0);
    send(1, 1); send(1, 0); send(1, 1); send(1, 0); send(1, 0);
    tests++; if ({out_valid, bit_cnt, frame_err} !== 5'b1_011_1) begin failed++; $display("FAIL t6_pre got %b exp 10111", {out_valid, bit_cnt, frame_err}); end
    #2 rst = 1'b1;
    #1;
    tests++; if ({out_data, out_valid} !== 5'b0) begin failed++; $display("FAIL t6_rst_out got %b exp 00000", {out_data, out_valid}); end
    tests++; if ({bit_cnt, overrun, frame_err} !== 5'b0) begin failed++; $display("FAIL t6_rst_state got %b exp 00000", {bit_cnt, overrun, frame_err}); end
    step();
    rst = 1'b0;
    send(1, 0);
    tests++; if (bit_cnt !== 3'd0) begin failed++; $display("FAIL t6_hunt got %0d exp 0", bit_cnt); end
    out_ready = 1'b1;
    send(1, 1); send(1, 0); send(0, 0); send(0, 0);
    tests++; if ({out_valid, out_data} !== 5'b1_1100) begin failed++; $display("FAIL t6_word got %b exp 11100", {out_valid, out_data}); end
    tests++; if ({overrun, frame_err} !== 2'b00) begin failed++; $display("FAIL t6_flags got %b exp 00", {overrun, frame_err}); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_no_sof();
    test_overrun();
    test_back_to_back();
    test_clr_priority();
    test_frame_err();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
